cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single common data bus (cdb_if) among the back-end execution units: ALU, MUL, DIV and AGU/load.
//  Each unit presents a completed result (tag + data); the arbiter grants one per cycle in round-robin order.
//  The granted result is registered onto the CDB, which broadcasts it to the front end (RAT/RS wakeup).
//  Sits inside tomasulo_back_end_cluster, between the unit result stages and the cdb_if driver.
// PARAMETERS
//  N_REQ   4   number of requesters (index = tomasulo_pkg::cdb_src_e: 0 ALU, 1 MUL, 2 DIV, 3 AGU)
//  TAG_W   6   ROB/RS tag width
//  XLEN    32  result data width
// PORTS
//  clk        in   1            clock; all state updates on the rising edge
//  rst        in   1            synchronous reset, active-high
//  flush      in   1            pipeline abort: suppress grants this cycle
//  req_valid  in   N_REQ        requester i holds a completed result
//  req_tag    in   N_REQ*TAG_W  packed tags; slice i = [i*TAG_W +: TAG_W]
//  req_data   in   N_REQ*XLEN   packed results; slice i = [i*XLEN +: XLEN]
//  req_ready  out  N_REQ        one-hot grant; combinational, same cycle as req_valid
//  cdb_valid  out  1            CDB broadcast valid (registered)
//  cdb_tag    out  TAG_W        broadcast tag (registered)
//  cdb_data   out  XLEN         broadcast data (registered)
//  cdb_src    out  2            index of the unit that produced the broadcast (registered)
// BEHAVIOUR
//  - Reset: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0. req_ready is 0 while rst=1.
//    Reset asserted mid-broadcast clears the outputs at that edge; the pending grant is lost.
//  - Handshake: a transfer from unit i occurs on an edge where req_valid[i] && req_ready[i].
//    A requester holds valid/tag/data stable until it sees ready. ready never depends on the next valid.
//  - Grant: req_ready = one-hot of the first valid requester, searching from rr_ptr upward, modulo N_REQ.
//    At most one bit of req_ready is set. If there are no valid requests, or flush=1 or rst=1, req_ready=0.
//  - Latency: exactly 1 cycle. Data accepted at edge k is on cdb_* during cycle k+1.
//    cdb_valid is high for exactly one cycle per transfer. Back-to-back transfers give cdb_valid high continuously.
//  - No-transfer cycle: cdb_valid<=0. cdb_tag, cdb_data and cdb_src hold their previous values
//    (consumers qualify on cdb_valid).
//  - Pointer: after a grant to i, rr_ptr <= (i+1) mod N_REQ, wrapping from 3 to 0. With no grant, rr_ptr holds.
//    Fairness bound: a continuously valid requester is granted within N_REQ cycles.
//  - Flush: no grant in that cycle; cdb_valid<=0 at that edge; rr_ptr holds.
//    A broadcast already registered (cycle of flush) still completes; the front end discards it on abort.
//  - No buffering inside the block. Back-pressure to the units is solely !req_ready.
//    Each unit owns its own result hold register and issue stall.
// STRUCTURE
//  - tomasulo_pkg: TAG_W, XLEN constants; cdb_src_e enum (SRC_ALU, SRC_MUL, SRC_DIV, SRC_AGU); N_CDB_REQ=4.
//  - Sub-module rr_grant (combinational): inputs req[N], ptr -> one-hot gnt[N] and gnt_idx.
//    Implement as a double-width masked priority search.
//  - Top: the rr_ptr register, the output register, and the cdb_if driver assignments.
// TESTING
//  1. Reset: hold rst 2 cycles with all req_valid=1.
//     -> req_ready=0 and cdb_valid=0 throughout; after release the first grant is ALU (ptr=0).
//  2. Single request: MUL valid, tag=6'h15, data=32'hDEADBEEF.
//     -> req_ready=4'b0010 same cycle; next cycle cdb_valid=1, tag=15, data=DEADBEEF, src=1; then cdb_valid=0.
//  3. All four valid and held: grants ALU,MUL,DIV,AGU,ALU on 5 consecutive cycles.
//     -> cdb_valid is high for 5 cycles and cdb_src follows 0,1,2,3,0.
//  4. Wrap: ptr=3 with only AGU and ALU valid -> AGU granted first, then ALU; ptr ends at 1.
//  5. Flush: DIV valid with flush=1 for 1 cycle -> no ready and cdb_valid=0 next cycle.
//     DIV is granted the cycle after flush drops; ptr is unchanged by the flush.
//  6. Stall: AGU valid, but ALU wins the grant.
//     -> AGU tag/data are held stable, AGU is granted next cycle, and its broadcast matches the held values.

Source files
------------

// File: rtl/tomasulo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tomasulo_pkg
//  Description : Shared constants and types for the Tomasulo back end.
//                TAG_W / XLEN  : default tag and result widths
//                N_CDB_REQ     : number of common-data-bus requesters
//                cdb_src_e     : requester index on the CDB
//  Revision    : 1.0 - initial release
// ============================================================================
package tomasulo_pkg;

   localparam int TAG_W     = 6;
   localparam int XLEN      = 32;
   localparam int N_CDB_REQ = 4;

   typedef enum logic [1:0] {
      SRC_ALU = 2'd0,
      SRC_MUL = 2'd1,
      SRC_DIV = 2'd2,
      SRC_AGU = 2'd3
   } cdb_src_e;

endpackage : tomasulo_pkg
`default_nettype wire

// File: rtl/cdb_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant
//  Description : Combinational round-robin grant. Finds the first set request
//                at or above ptr_i, wrapping modulo N.
//  Ports       : req_i       [N]      request vector
//                ptr_i       [IDX_W]  search start index
//                gnt_o       [N]      one-hot grant (zero if no request)
//                gnt_idx_o   [IDX_W]  index of the granted requester
//                gnt_valid_o          any request granted
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_valid_o
);

   logic [2*N-1:0] w_dbl;
   logic [2*N-1:0] w_masked;

   // The request vector is duplicated so that the wrap-around search becomes a
   // plain lowest-set-bit search: the lower copy is masked below the pointer,
   // the upper copy supplies the requests that come after the wrap.
   always_comb begin
      w_dbl       = {req_i, req_i};
      w_masked    = '0;
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      for (int j = 0; j < 2*N; j++) begin
         w_masked[j] = w_dbl[j] && (j >= int'(ptr_i));
      end
      // Descending scan: the last hit written is the lowest set bit.
      for (int j = 2*N-1; j >= 0; j--) begin
         if (w_masked[j]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = IDX_W'(j % N);
         end
      end
      gnt_o = gnt_valid_o ? (N'(1) << gnt_idx_o) : '0;
   end

endmodule : rr_grant
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Round-robin arbiter for the common data bus. One completed
//                result per cycle is granted and registered onto the CDB.
//  Ports       : clk, rst (sync, active-high), flush (suppress grants)
//                req_valid/req_tag/req_data : packed per-requester results
//                req_ready                  : one-hot combinational grant
//                cdb_valid/tag/data/src     : registered broadcast
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
   parameter int N_REQ = tomasulo_pkg::N_CDB_REQ,
   parameter int TAG_W = tomasulo_pkg::TAG_W,
   parameter int XLEN  = tomasulo_pkg::XLEN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*TAG_W-1:0] req_tag,
   input  logic [N_REQ*XLEN-1:0]  req_data,
   output logic [N_REQ-1:0]   req_ready,
   output logic               cdb_valid,
   output logic [TAG_W-1:0]   cdb_tag,
   output logic [XLEN-1:0]    cdb_data,
   output logic [1:0]         cdb_src
);

   import tomasulo_pkg::*;

   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_any;
   logic             xfer;
   logic [TAG_W-1:0] tag_d;
   logic [XLEN-1:0]  data_d;

   logic             cdb_valid_q;
   logic [TAG_W-1:0] cdb_tag_q;
   logic [XLEN-1:0]  cdb_data_q;
   cdb_src_e         cdb_src_q;

   rr_grant #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_grant (
      .req_i       (req_valid),
      .ptr_i       (ptr_q),
      .gnt_o       (gnt),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_any)
   );

   // Grant is withheld during reset and flush; a transfer is simply a grant.
   always_comb begin
      xfer      = gnt_any && !rst && !flush;
      req_ready = xfer ? gnt : '0;
      tag_d     = req_tag[int'(gnt_idx)*TAG_W +: TAG_W];
      data_d    = req_data[int'(gnt_idx)*XLEN +: XLEN];
      ptr_d     = (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         cdb_src_q   <= SRC_ALU;
      end else begin
         cdb_valid_q <= xfer;
         // Payload holds when nothing is granted; consumers qualify on valid.
         if (xfer) begin
            ptr_q      <= ptr_d;
            cdb_tag_q  <= tag_d;
            cdb_data_q <= data_d;
            cdb_src_q  <= cdb_src_e'(2'(gnt_idx));
         end
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_data  = cdb_data_q;
   assign cdb_src   = cdb_src_q;

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter: directed scenarios
//                followed by randomized handshaking traffic, compared against
//                a behavioural round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int TW = 6;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic [N-1:0]    req_valid;
   logic [N*TW-1:0] req_tag;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_data;
   logic [1:0]      cdb_src;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   int          m_ptr;
   logic        m_valid;
   logic [TW-1:0] m_tag;
   logic [DW-1:0] m_data;
   int          m_src;
   logic [N-1:0] last_gnt;
   int          waitc [N];

   // random-traffic requester hold registers
   logic          hv [N];
   logic [TW-1:0] ht [N];
   logic [DW-1:0] hd [N];

   always #5 clk = ~clk;

   cdb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .req_valid (req_valid),
      .req_tag   (req_tag),
      .req_data  (req_data),
      .req_ready (req_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // First valid requester at or after p, counting modulo N; -1 if none.
   function automatic int model_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
      req_valid[i]          = v;
      req_tag[i*TW +: TW]   = t;
      req_data[i*DW +: DW]  = d;
   endtask

   // One clock: check the grant before the edge, advance the model at the
   // edge, check the registered broadcast just after it.
   task automatic cycle();
      int pick;
      logic [N-1:0] eg;
      @(negedge clk);
      pick = model_pick(req_valid, m_ptr);
      eg   = (rst || flush || pick < 0) ? '0 : N'(1) << pick;
      chk("req_ready", 64'(req_ready), 64'(eg));
      for (int i = 0; i < N; i++) begin
         if (rst || !req_valid[i] || eg[i]) waitc[i] = 0;
         else if (!flush) waitc[i]++;
         if (req_valid[i]) chk("fairness", 64'(waitc[i] < N), 64'(1));
      end
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = 0; m_ptr = 0;
      end else if (eg != '0) begin
         m_valid = 1'b1;
         m_tag   = req_tag[pick*TW +: TW];
         m_data  = req_data[pick*DW +: DW];
         m_src   = pick;
         m_ptr   = (pick + 1) % N;
      end else begin
         m_valid = 1'b0;
      end
      last_gnt = eg;
      #1;
      chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
      chk("cdb_tag",   64'(cdb_tag),   64'(m_tag));
      chk("cdb_data",  64'(cdb_data),  64'(m_data));
      chk("cdb_src",   64'(cdb_src),   64'(m_src));
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      req_valid = '0; req_tag = '0; req_data = '0;
      m_ptr = 0; m_valid = 0; m_tag = '0; m_data = '0; m_src = 0; last_gnt = '0;
      for (int i = 0; i < N; i++) begin
         waitc[i] = 0; hv[i] = 0; ht[i] = '0; hd[i] = '0;
      end

      // 1. reset held two cycles with every requester valid
      for (int i = 0; i < N; i++) set_req(i, 1'b1, TW'(i + 1), DW'(32'hA000_0000 + i));
      cycle();
      chk("t1_rst_ready", 64'(req_ready), 64'(0));
      cycle();
      chk("t1_rst_valid", 64'(cdb_valid), 64'(0));
      rst = 1'b0;
      cycle();
      chk("t1_first_src", 64'(cdb_src), 64'(0));
      chk("t1_first_tag", 64'(cdb_tag), 64'(1));
      req_valid = '0;
      cycle();

      // 2. single MUL request
      set_req(1, 1'b1, 6'h15, 32'hDEADBEEF);
      cycle();
      chk("t2_valid", 64'(cdb_valid), 64'(1));
      chk("t2_tag",   64'(cdb_tag),   64'(6'h15));
      chk("t2_data",  64'(cdb_data),  64'(32'hDEADBEEF));
      chk("t2_src",   64'(cdb_src),   64'(1));
      req_valid = '0;
      cycle();
      chk("t2_drop",  64'(cdb_valid), 64'(0));

      // 3. all four held from a fresh pointer
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, TW'(8 + i), DW'(32'h3000 + i));
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("t3_valid", 64'(cdb_valid), 64'(1));
         chk("t3_src",   64'(cdb_src),   64'(k % N));
      end

      // 4. wrap: walk pointer to 3, then only AGU and ALU valid
      cycle();
      cycle();
      req_valid = 4'b1001;
      cycle();
      chk("t4_agu", 64'(cdb_src), 64'(3));
      cycle();
      chk("t4_alu", 64'(cdb_src), 64'(0));
      req_valid = 4'b1111;
      cycle();
      chk("t4_ptr1", 64'(cdb_src), 64'(1));

      // 5. flush with DIV valid
      req_valid = 4'b0100;
      flush = 1'b1;
      cycle();
      chk("t5_flush_valid", 64'(cdb_valid), 64'(0));
      flush = 1'b0;
      cycle();
      chk("t5_div", 64'(cdb_src), 64'(2));
      req_valid = 4'b1111;
      cycle();
      chk("t5_ptr", 64'(cdb_src), 64'(3));

      // 6. stall: ALU wins, AGU holds and is granted next
      set_req(0, 1'b1, 6'h2A, 32'h0000_1111);
      set_req(1, 1'b0, '0, '0);
      set_req(2, 1'b0, '0, '0);
      set_req(3, 1'b1, 6'h33, 32'hCAFE_F00D);
      cycle();
      chk("t6_alu", 64'(cdb_src), 64'(0));
      req_valid[0] = 1'b0;
      cycle();
      chk("t6_agu_src",  64'(cdb_src),  64'(3));
      chk("t6_agu_tag",  64'(cdb_tag),  64'(6'h33));
      chk("t6_agu_data", 64'(cdb_data), 64'(32'hCAFE_F00D));
      req_valid = '0;
      cycle();

      // random traffic obeying the valid/ready hold rule
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (last_gnt[i]) hv[i] = 1'b0;
            if (!hv[i] && $urandom_range(0, 2) == 0) begin
               hv[i] = 1'b1;
               ht[i] = TW'($urandom);
               hd[i] = $urandom;
            end
            set_req(i, hv[i], ht[i], hd[i]);
         end
         flush = ($urandom_range(0, 9) == 0);
         rst   = ($urandom_range(0, 59) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_cdb_arbiter
`default_nettype wire
